// File: rtl/sevseg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sevseg_pkg
// Brief   : Shared seven-segment definitions: segment bit indices, glyph
//           table, glyph-to-hex lookup and reader FSM state encodings.
// Revision: 1.0 - initial release
// ============================================================================
package sevseg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Index n holds the active-high segment pattern for hex value n.
  localparam logic [6:0] c_glyph_table [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_count = 2'd1;
  localparam logic [1:0] c_st_hold  = 2'd2;

  // Returns {err, hex}; unknown patterns yield {1, 0}.
  function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
    logic [4:0] res;
    res = {1'b1, 4'h0};
    for (int i = 0; i < 16; i++) begin
      if (seg == c_glyph_table[i]) begin
        res = {1'b0, 4'(i)};
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sevseg_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module  : sevseg_glyph_decode
// Brief   : Combinational glyph decode: 7 segment lines -> err, hex, onehot.
// Revision: 1.0 - initial release
// ============================================================================
module sevseg_glyph_decode
  import sevseg_pkg::*;
(
  input  logic [6:0]  seg,
  output logic        err,
  output logic [3:0]  hex,
  output logic [15:0] onehot
);

  logic [4:0] w_dec;

  always_comb begin
    w_dec  = seg_to_hex(seg);
    err    = w_dec[4];
    hex    = w_dec[3:0];
    onehot = '0;
    if (!w_dec[4]) begin
      onehot[w_dec[3:0]] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seven_segment_reader.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_reader
// Brief   : Samples a multiplexed seven-segment bus, captures each stable
//           glyph once and returns hex/onehot over a valid/ready slot.
//           Optional decimal point capture: define SEVSEG_READER_DP_EN.
// Revision: 1.0 - initial release
// ============================================================================
module seven_segment_reader
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int DIG_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_i,
  input  logic [NUM_DIGITS-1:0] dig_i,
`ifdef SEVSEG_READER_DP_EN
  input  logic                  seg_dp_i,
  output logic                  out_dp,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIG_W-1:0]      out_digit,
  output logic [3:0]            out_hex,
  output logic [15:0]           out_onehot,
  output logic                  out_err,
  output logic                  overflow,
  input  logic                  overflow_clr
);

`ifdef SEVSEG_READER_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
  endfunction

  function automatic logic [DIG_W-1:0] dig_index(input logic [NUM_DIGITS-1:0] v);
    logic [DIG_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) begin
        idx = DIG_W'(i);
      end
    end
    return idx;
  endfunction

  logic [SEG_W-1:0]      r_seg_s;
  logic [NUM_DIGITS-1:0] r_dig_s;
  logic [SEG_W-1:0]      r_ref_seg;
  logic [NUM_DIGITS-1:0] r_ref_dig;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;

  logic w_match;
  logic w_onehot;
  logic w_at_max;
  logic w_capture;
  logic w_relatch;
  logic w_cnt_inc;

  logic        w_dec_err;
  logic [3:0]  w_dec_hex;
  logic [15:0] w_dec_onehot;

  logic             r_out_valid;
  logic [DIG_W-1:0] r_out_digit;
  logic [3:0]       r_out_hex;
  logic [15:0]      r_out_onehot;
  logic             r_out_err;
  logic             r_overflow;
  logic             w_load;
  logic             w_drop;

  // Input sample stage; the bus is assumed synchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s <= '0;
      r_dig_s <= '0;
    end else begin
`ifdef SEVSEG_READER_DP_EN
      r_seg_s <= {seg_dp_i, seg_i};
`else
      r_seg_s <= seg_i;
`endif
      r_dig_s <= dig_i;
    end
  end

  assign w_match  = ({r_seg_s, r_dig_s} == {r_ref_seg, r_ref_dig});
  assign w_onehot = is_onehot(r_dig_s);
  assign w_at_max = (r_cnt == c_cnt_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_onehot) w_state_nxt = c_st_count;
      end
      c_st_count: begin
        if (!w_match)      w_state_nxt = w_onehot ? c_st_count : c_st_idle;
        else if (w_at_max) w_state_nxt = c_st_hold;
      end
      c_st_hold: begin
        if (!w_match) w_state_nxt = w_onehot ? c_st_count : c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // A full count captures the ref glyph even if this sample already differs;
  // the new pattern then restarts counting without losing a cycle.
  always_comb begin
    w_capture = 1'b0;
    w_relatch = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      c_st_idle: begin
        w_relatch = w_onehot;
      end
      c_st_count: begin
        w_capture = w_at_max;
        w_relatch = !w_match && w_onehot;
        w_cnt_inc = w_match && !w_at_max;
      end
      c_st_hold: begin
        w_relatch = !w_match && w_onehot;
      end
      default: begin
        w_relatch = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_ref_seg <= '0;
      r_ref_dig <= '0;
    end else begin
      if (w_relatch) begin
        r_ref_seg <= r_seg_s;
        r_ref_dig <= r_dig_s;
        r_cnt     <= c_cnt_one;
      end else if (w_state_nxt == c_st_idle) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  sevseg_glyph_decode u_decode (
    .seg    (r_ref_seg[6:0]),
    .err    (w_dec_err),
    .hex    (w_dec_hex),
    .onehot (w_dec_onehot)
  );

  assign w_load = w_capture && (!r_out_valid || out_ready);
  assign w_drop = w_capture && !w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_digit  <= '0;
      r_out_hex    <= '0;
      r_out_onehot <= '0;
      r_out_err    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid  <= 1'b1;
        r_out_digit  <= dig_index(r_ref_dig);
        r_out_hex    <= w_dec_hex;
        r_out_onehot <= w_dec_onehot;
        r_out_err    <= w_dec_err;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef SEVSEG_READER_DP_EN
  logic r_out_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_dp <= 1'b0;
    end else if (w_load) begin
      r_out_dp <= r_ref_seg[SEG_W-1];
    end
  end

  assign out_dp = r_out_dp;
`endif

  assign out_valid  = r_out_valid;
  assign out_digit  = r_out_digit;
  assign out_hex    = r_out_hex;
  assign out_onehot = r_out_onehot;
  assign out_err    = r_out_err;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_segment_reader
// Brief   : Directed self-checking bench for seven_segment_reader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seven_segment_reader;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic        out_ready;
  logic        overflow_clr;
  logic        out_valid;
  logic [1:0]  out_digit;
  logic [3:0]  out_hex;
  logic [15:0] out_onehot;
  logic        out_err;
  logic        overflow;
`ifdef SEVSEG_READER_DP_EN
  logic        out_dp;
`endif

  int vectors = 0;
  int errs    = 0;

  typedef struct packed {
    logic [1:0]  digit;
    logic        err;
    logic [3:0]  hex;
    logic [15:0] onehot;
  } res_t;

  res_t q[$];

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seven_segment_reader #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_i        (seg),
    .dig_i        (dig),
`ifdef SEVSEG_READER_DP_EN
    .seg_dp_i     (1'b0),
    .out_dp       (out_dp),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_digit    (out_digit),
    .out_hex      (out_hex),
    .out_onehot   (out_onehot),
    .out_err      (out_err),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every transfer that the next rising edge will accept.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q.push_back({out_digit, out_err, out_hex, out_onehot});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    rst_n        = 1'b0;
    seg          = 7'h00;
    dig          = 4'b0000;
    out_ready    = 1'b1;
    overflow_clr = 1'b0;
    cyc(2);
    check("rst_valid",  32'(out_valid),  32'h0);
    check("rst_digit",  32'(out_digit),  32'h0);
    check("rst_hex",    32'(out_hex),    32'h0);
    check("rst_onehot", 32'(out_onehot), 32'h0);
    check("rst_err",    32'(out_err),    32'h0);
    check("rst_ovf",    32'(overflow),   32'h0);
    rst_n = 1'b1;
    cyc(2);

    // Single capture latency and fields
    q.delete();
    seg = 7'h6D;
    dig = 4'b0010;
    k   = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      if (out_valid) begin
        k = i;
        break;
      end
    end
    check("latency",    32'(k),          32'd10);
    check("t1_digit",   32'(out_digit),  32'd1);
    check("t1_hex",     32'(out_hex),    32'h5);
    check("t1_onehot",  32'(out_onehot), 32'h0020);
    check("t1_err",     32'(out_err),    32'h0);
    cyc(4);
    check("t1_count",   32'(q.size()),   32'd1);
    check("t1_drop",    32'(out_valid),  32'h0);

    // Sweep all glyphs on digit 3, then a blank pattern
    q.delete();
    dig = 4'b1000;
    for (int n = 0; n < 16; n++) begin
      seg = glyph[n];
      cyc(10);
    end
    seg = 7'h00;
    cyc(12);
    check("sweep_count", 32'(q.size()), 32'd17);
    for (int n = 0; n < 16; n++) begin
      if (n < q.size()) begin
        check($sformatf("sweep_hex%0d", n),    32'(q[n].hex),    32'(n));
        check($sformatf("sweep_oh%0d", n),     32'(q[n].onehot), 32'h1 << n);
        check($sformatf("sweep_err%0d", n),    32'(q[n].err),    32'h0);
        check($sformatf("sweep_digit%0d", n),  32'(q[n].digit),  32'd3);
      end
    end
    if (q.size() > 16) begin
      check("blank_err",    32'(q[16].err),    32'h1);
      check("blank_hex",    32'(q[16].hex),    32'h0);
      check("blank_onehot", 32'(q[16].onehot), 32'h0);
    end

    // Glitch in the middle of a stable interval
    q.delete();
    dig = 4'b0001;
    seg = 7'h7F;
    cyc(5);
    seg = 7'h4F;
    cyc(1);
    seg = 7'h7F;
    cyc(9);
    cyc(5);
    check("glitch_count", 32'(q.size()), 32'd1);
    if (q.size() > 0) begin
      check("glitch_hex",   32'(q[0].hex),   32'h8);
      check("glitch_digit", 32'(q[0].digit), 32'd0);
    end

    // Backpressure and overflow
    q.delete();
    out_ready = 1'b0;
    seg = 7'h5B;
    cyc(10);
    check("bp_valid1", 32'(out_valid), 32'h1);
    check("bp_hex1",   32'(out_hex),   32'h2);
    seg = 7'h4F;
    cyc(10);
    check("bp_hold",   32'(out_hex),   32'h2);
    check("bp_ovf",    32'(overflow),  32'h1);
    out_ready = 1'b1;
    cyc(1);
    check("bp_accept", 32'(out_valid), 32'h0);
    cyc(5);
    check("bp_count",  32'(q.size()),  32'd1);
    if (q.size() > 0) begin
      check("bp_qhex", 32'(q[0].hex), 32'h2);
    end
    check("bp_ovf_sticky", 32'(overflow), 32'h1);
    overflow_clr = 1'b1;
    cyc(1);
    overflow_clr = 1'b0;
    check("bp_ovf_clr", 32'(overflow), 32'h0);

    // Non-one-hot digit select never captures
    q.delete();
    dig = 4'b0110;
    seg = 7'h06;
    cyc(20);
    check("nonoh_count", 32'(q.size()),  32'd0);
    check("nonoh_valid", 32'(out_valid), 32'h0);
    dig = 4'b0100;
    seg = 7'h39;
    cyc(10);
    check("c_valid",  32'(out_valid),  32'h1);
    check("c_hex",    32'(out_hex),    32'hC);
    check("c_digit",  32'(out_digit),  32'd2);
    check("c_onehot", 32'(out_onehot), 32'h1000);
    cyc(3);

    // Asynchronous reset with a pending result and a partial count
    out_ready = 1'b0;
    dig = 4'b0010;
    seg = 7'h6F;
    cyc(10);
    check("pend_valid", 32'(out_valid), 32'h1);
    check("pend_hex",   32'(out_hex),   32'h9);
    dig = 4'b0001;
    seg = 7'h66;
    cyc(5);
    rst_n = 1'b0;
    #2;
    check("arst_valid",  32'(out_valid),  32'h0);
    check("arst_hex",    32'(out_hex),    32'h0);
    check("arst_digit",  32'(out_digit),  32'h0);
    check("arst_onehot", 32'(out_onehot), 32'h0);
    check("arst_err",    32'(out_err),    32'h0);
    check("arst_ovf",    32'(overflow),   32'h0);
    cyc(2);
    q.delete();
    out_ready = 1'b1;
    rst_n = 1'b1;
    cyc(9);
    check("rel_early", 32'(out_valid), 32'h0);
    cyc(1);
    check("rel_valid", 32'(out_valid), 32'h1);
    check("rel_hex",   32'(out_hex),   32'h4);
    cyc(4);
    check("rel_count", 32'(q.size()),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
- Receive-side counterpart of the one-hot to seven-segment decoder.
- Watches a multiplexed seven-segment bus (segment lines plus one-hot digit select) and waits until the bus is stable.
- Converts each captured glyph back to a hex nibble and to the team's 16-bit one-hot digit code.
- Delivers results over a valid/ready handshake.
- Used for loopback self-test of display drivers and for scraping display buses in bring-up benches.

Parameters:
- NUM_DIGITS, 4: number of digit-select lines; ≥1.
- STABLE_CYCLES, 8: consecutive identical samples required before capture; ≥1.
- DIG_W, $clog2(NUM_DIGITS) (min 1): width of digit index output.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- seg_i  in  7  segment lines, bit0=a … bit6=g, active-high.
- dig_i  in  NUM_DIGITS  digit select, active-high; valid only when exactly one bit is set.
- out_valid  out  1  capture result available.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- out_digit  out  DIG_W  index of the set bit in dig_i at capture.
- out_hex  out  4  decoded value 0–F.
- out_onehot  out  16  bit n set for value n; all zero on error.
- out_err  out  1  captured pattern is not in the glyph table.
- overflow  out  1  sticky; a capture was dropped because the output was full.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset: clock domain clk; reset is asynchronous, active-low (rst_n). All outputs go to 0, FSM to IDLE, counter to 0, input sample registers to 0.
- Input stage: seg_i and dig_i are registered once (s_seg, s_dig) before use. No synchroniser is built in; inputs are synchronous to clk.
- Glyph table (hex: seg): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
  - Any other pattern, including 00, decodes to err=1, hex=0, onehot=0.
- FSM states: IDLE, COUNT, HOLD.
  - IDLE: s_dig is not one-hot. Counter is 0. Moves to COUNT when s_dig becomes one-hot, latching ref={s_seg,s_dig} with counter=1.
  - COUNT: each cycle {s_seg,s_dig}==ref increments the counter.
    - On a mismatch: if the new s_dig is one-hot, relatch ref and set counter=1; otherwise go to IDLE.
    - When the counter reaches STABLE_CYCLES, capture and go to HOLD.
    - With STABLE_CYCLES=1, the capture happens in the first COUNT cycle.
  - HOLD: waits for {s_seg,s_dig}!=ref, then behaves as the COUNT mismatch case. This guarantees one capture per stable interval, with no repeats.
- Capture:
  - If the output slot is empty, or is being accepted this same cycle, load out_* and assert out_valid on the next clock edge.
  - Otherwise the new result is dropped and overflow is set. The held result is unchanged.
- Latency: seg_i/dig_i change → out_valid high = STABLE_CYCLES+2 clk edges (1 input register, STABLE_CYCLES count, 1 output register).
- Handshake:
  - out_valid stays high and out_* stay stable until accepted.
  - out_valid deasserts the edge after out_valid&&out_ready, unless a capture in that same cycle reloads it.
- overflow: set by a dropped capture, cleared by overflow_clr. Set wins if both occur in the same cycle.
- Reset mid-operation discards any pending result and in-progress count.
- Counter saturates; it is never larger than STABLE_CYCLES.

Optional Feature:
- Macro SEVSEG_READER_DP_EN.
- Defined:
  - Adds input seg_dp_i (1) and output out_dp (1).
  - DP is registered, included in the stability compare (ref is 8 bits + dig), and captured into out_dp.
  - DP does not affect glyph decode or err.
- Undefined: neither port exists; behaviour is as above.

Decomposition:
- Package sevseg_pkg:
  - segment-bit index constants (SEG_A … SEG_G);
  - the 16-entry glyph constant array;
  - function seg_to_hex (returns {err,hex}).
  - The existing one-hot-to-segment decoder uses the same package so the table is shared.
- Sub-module sevseg_glyph_decode: purely combinational 7 → {err, hex[3:0], onehot[15:0]}. It is instantiated once on the ref path.
- The FSM, counter and output slot live in the top module.

Test Plan:
- NUM_DIGITS=4, STABLE_CYCLES=8, out_ready=1; drive seg=6D, dig=0010 for 12 cycles → one out_valid pulse 10 edges after the drive, with out_digit=1, out_hex=5, out_onehot=0x0020, out_err=0.
- Sweep all 16 glyphs on digit 3, each held 10 cycles → 16 results in order 0…F, onehot=1<<n; then seg=00 → err=1, onehot=0.
- Glitch: seg=7F for 5 cycles, 4F for 1 cycle, 7F for 9 cycles → exactly one result, hex=8; no capture of 3.
- Backpressure: out_ready=0, capture 2 then 3 → out_hex holds 2, overflow=1; raise out_ready → 2 accepted, no 3; overflow_clr → overflow=0.
- dig=0110 (not one-hot) held 20 cycles → no capture, FSM stays IDLE; dig=0100 with seg=39 → hex=C, digit=2.
- rst_n low mid-count (cycle 5) and while out_valid is pending → all outputs 0 asynchronously, no result after release until a fresh STABLE_CYCLES interval completes.
